// File: rtl/hls_array_mem_if.sv
// Kernel-side single-port array bus plus host init/readback port for hls_array_mem.
// master = kernel/host driver side, slave = memory side.
interface hls_array_mem_if #(
    parameter int AW = 32
);
    logic [AW-1:0] address0;
    logic          ce0;
    logic          we0;
    logic [31:0]   ad0;
    logic [31:0]   q0;
    logic          q0_vld;
    logic          init_en;
    logic          init_we;
    logic [AW-1:0] init_addr;
    logic [31:0]   init_wdata;
    logic [31:0]   init_rdata;
    logic          init_rvld;

    modport master (
        output address0, ce0, we0, ad0,
        output init_en, init_we, init_addr, init_wdata,
        input  q0, q0_vld, init_rdata, init_rvld
    );

    modport slave (
        input  address0, ce0, we0, ad0,
        input  init_en, init_we, init_addr, init_wdata,
        output q0, q0_vld, init_rdata, init_rvld
    );
endinterface

// File: rtl/hls_array_mem.sv
// Array memory behind one HLS kernel array argument, with host preload/readback, OOB/collision flags and stats.
// Kernel reads return after RD_LAT cycles, host reads after 1; no backpressure, one access per port per cycle.
module hls_array_mem #(
    parameter int DEPTH  = 1024,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    hls_array_mem_if.slave      mem_if,
    input  logic                clr_stats,
    output logic                oob_err,
    output logic                col_err,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]       mem [DEPTH];

    logic              k_rd, k_wr, k_wr_ok, k_in;
    logic              h_rd, h_wr, h_in;
    logic [IW-1:0]     k_idx, h_idx;

    logic [RD_LAT-1:0] pipe_vld;
    logic [31:0]       pipe_dat [RD_LAT];
    logic [31:0]       h_rdata;
    logic              h_rvld;
    logic [31:0]       rd_cnt, wr_cnt;
    logic              oob_q, col_q;

    assign k_rd    = mem_if.ce0 & ~mem_if.we0;
    assign k_wr    = mem_if.ce0 &  mem_if.we0;
    assign h_rd    = mem_if.init_en & ~mem_if.init_we;
    assign h_wr    = mem_if.init_en &  mem_if.init_we;
    // Host owns the single write port; a concurrent kernel write is dropped.
    assign k_wr_ok = k_wr & ~h_wr;

    assign k_in  = (mem_if.address0  < AW'(DEPTH));
    assign h_in  = (mem_if.init_addr < AW'(DEPTH));
    assign k_idx = mem_if.address0[IW-1:0];
    assign h_idx = mem_if.init_addr[IW-1:0];

    // Contents are deliberately not reset so preloaded data survives sys_rst_n.
    always_ff @(posedge sys_clk) begin
        if (h_wr && h_in) begin
            mem[h_idx] <= mem_if.init_wdata;
        end else if (k_wr_ok && k_in) begin
            mem[k_idx] <= mem_if.ad0;
        end
    end

    // Stage data only advances with its valid so the last stage holds q0 between reads.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= k_rd;
            if (k_rd) begin
                pipe_dat[0] <= k_in ? mem[k_idx] : 32'h0;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_rvld  <= 1'b0;
            h_rdata <= '0;
        end else begin
            h_rvld <= h_rd;
            if (h_rd) begin
                h_rdata <= h_in ? mem[h_idx] : 32'h0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            oob_q  <= 1'b0;
            col_q  <= 1'b0;
        end else if (clr_stats) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            oob_q  <= 1'b0;
            col_q  <= 1'b0;
        end else begin
            if (k_rd && (rd_cnt != 32'hFFFF_FFFF)) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (k_wr_ok && (wr_cnt != 32'hFFFF_FFFF)) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if ((mem_if.ce0 && !k_in) || (mem_if.init_en && !h_in)) begin
                oob_q <= 1'b1;
            end
            if (k_wr && h_wr) begin
                col_q <= 1'b1;
            end
        end
    end

    assign mem_if.q0         = pipe_dat[RD_LAT-1];
    assign mem_if.q0_vld     = pipe_vld[RD_LAT-1];
    assign mem_if.init_rdata = h_rdata;
    assign mem_if.init_rvld  = h_rvld;
    assign rd_count          = rd_cnt;
    assign wr_count          = wr_cnt;
    assign oob_err           = oob_q;
    assign col_err           = col_q;

endmodule
